// File: rtl/vdp1_pkg.sv
// Shared types and constants for the VDP1 command-table sequencer.
package vdp1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_DISPATCH,
    ST_WAIT_DONE,
    ST_NEXT
  } state_t;

  localparam logic [1:0] JP_NEXT   = 2'b00;
  localparam logic [1:0] JP_ASSIGN = 2'b01;
  localparam logic [1:0] JP_CALL   = 2'b10;
  localparam logic [1:0] JP_RETURN = 2'b11;

  localparam int CTRL_END    = 15;
  localparam int CTRL_SKIP   = 14;
  localparam int CTRL_JP_LO  = 12;
  localparam int TABLE_WORDS = 16;
  localparam int FETCH_WORDS = 15;

endpackage

// File: rtl/vdp1_vram_rd_port.sv
// Single-outstanding VRAM read requester: holds req/addr until ack and
// registers the returned word so it is presented one cycle after the ack.
module vdp1_vram_rd_port #(
  parameter int ADDR_W = 18
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_rd,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_abort,
  output logic              o_vram_req,
  output logic [ADDR_W-1:0] o_vram_addr,
  input  logic              i_vram_ack,
  input  logic [15:0]       i_vram_rdata,
  output logic              o_rd_valid,
  output logic [15:0]       o_rd_data
);

  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic [15:0]       r_data;
  logic              w_accept;

  // An abort in the ack cycle discards the word so nothing leaks downstream.
  assign w_accept = r_req && i_vram_ack && !i_abort;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) r_data <= i_vram_rdata;
      if (i_abort) begin
        r_req <= 1'b0;
      end else if (i_rd) begin
        r_req  <= 1'b1;
        r_addr <= i_rd_addr;
      end else if (w_accept) begin
        r_req <= 1'b0;
      end
    end
  end

  assign o_vram_req  = r_req;
  assign o_vram_addr = r_addr;
  assign o_rd_valid  = r_valid;
  assign o_rd_data   = r_data;

endmodule

// File: rtl/vdp1_cmd_sequencer.sv
// Walks the VDP1 command-table list in VRAM, streams each table to the draw
// engine and follows the CMDCTRL jump/skip/end control.
module vdp1_cmd_sequencer
  import vdp1_pkg::*;
#(
  parameter int          ADDR_W   = 18,
  parameter logic [15:0] MAX_CMDS = 16'hFFFF
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_stop,
  output logic              o_vram_req,
  output logic [ADDR_W-1:0] o_vram_addr,
  input  logic              i_vram_ack,
  input  logic [15:0]       i_vram_rdata,
  output logic              o_cmd_wr,
  output logic [3:0]        o_cmd_idx,
  output logic [15:0]       o_cmd_word,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  input  logic              i_draw_done,
  output logic              o_busy,
  output logic              o_list_end,
  output logic              o_overflow,
  output logic [15:0]       o_cmd_count
);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_cur_addr, w_cur_next;
  logic [ADDR_W-1:0] r_ret, w_ret_next;
  logic              r_ret_valid, w_ret_valid_next;
  logic [3:0]        r_idx, w_idx_next;
  logic              r_skip, w_skip_next;
  logic [1:0]        r_jp, w_jp_next;
  logic [15:0]       r_link, w_link_next;
  logic              r_list_end, w_list_end_next;
  logic              r_overflow, w_overflow_next;
  logic [15:0]       r_cmd_count, w_cmd_count_next;
  logic [ADDR_W-1:0] w_nxt, w_link_addr, w_rd_addr;
  logic              w_rd, w_abort, w_rd_valid;
  logic [15:0]       w_rd_data;

  assign w_abort     = i_stop && (r_state != ST_IDLE);
  assign w_nxt       = r_cur_addr + ADDR_W'(TABLE_WORDS);
  assign w_link_addr = ADDR_W'({r_link, 2'b00});

  vdp1_vram_rd_port #(.ADDR_W(ADDR_W)) u_rd_port (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_rd         (w_rd),
    .i_rd_addr    (w_rd_addr),
    .i_abort      (w_abort),
    .o_vram_req   (o_vram_req),
    .o_vram_addr  (o_vram_addr),
    .i_vram_ack   (i_vram_ack),
    .i_vram_rdata (i_vram_rdata),
    .o_rd_valid   (w_rd_valid),
    .o_rd_data    (w_rd_data)
  );

  always_comb begin
    w_state_next     = r_state;
    w_cur_next       = r_cur_addr;
    w_ret_next       = r_ret;
    w_ret_valid_next = r_ret_valid;
    w_idx_next       = r_idx;
    w_skip_next      = r_skip;
    w_jp_next        = r_jp;
    w_link_next      = r_link;
    w_list_end_next  = r_list_end;
    w_overflow_next  = r_overflow;
    w_cmd_count_next = r_cmd_count;
    w_rd             = 1'b0;
    if (w_abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) begin
          w_cur_next       = '0;
          w_list_end_next  = 1'b0;
          w_overflow_next  = 1'b0;
          w_cmd_count_next = '0;
          w_ret_valid_next = 1'b0;
          w_idx_next       = '0;
          w_rd             = 1'b1;
          w_state_next     = ST_FETCH;
        end
        ST_FETCH: if (w_rd_valid) begin
          if (r_idx == 4'd1) w_link_next = w_rd_data;
          if (r_idx == 4'd0 && w_rd_data[CTRL_END]) begin
            w_list_end_next = 1'b1;
            w_state_next    = ST_IDLE;
          end else begin
            if (r_idx == 4'd0) begin
              w_skip_next = w_rd_data[CTRL_SKIP];
              w_jp_next   = w_rd_data[CTRL_JP_LO+1:CTRL_JP_LO];
            end
            if (r_idx == 4'(FETCH_WORDS - 1)) begin
              w_idx_next   = '0;
              w_state_next = ST_DECODE;
            end else begin
              w_idx_next = r_idx + 4'd1;
              w_rd       = 1'b1;
            end
          end
        end
        ST_DECODE: w_state_next = r_skip ? ST_NEXT : ST_DISPATCH;
        ST_DISPATCH: if (i_cmd_ready) begin
          w_cmd_count_next = r_cmd_count + 16'd1;
          w_state_next     = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: if (i_draw_done) w_state_next = ST_NEXT;
        ST_NEXT: begin
          case (r_jp)
            JP_NEXT:   w_cur_next = w_nxt;
            JP_ASSIGN: w_cur_next = w_link_addr;
            JP_CALL: begin
              w_ret_next       = w_nxt;
              w_ret_valid_next = 1'b1;
              w_cur_next       = w_link_addr;
            end
            default: begin
              // Return without a pending call falls through to the next table.
              if (r_ret_valid) begin
                w_cur_next       = r_ret;
                w_ret_valid_next = 1'b0;
              end else begin
                w_cur_next = w_nxt;
              end
            end
          endcase
          if (r_cmd_count == MAX_CMDS) begin
            w_overflow_next = 1'b1;
            w_state_next    = ST_IDLE;
          end else begin
            w_idx_next   = '0;
            w_rd         = 1'b1;
            w_state_next = ST_FETCH;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
    w_rd_addr = w_cur_next + ADDR_W'(w_idx_next);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_cur_addr  <= '0;
      r_ret       <= '0;
      r_ret_valid <= 1'b0;
      r_idx       <= '0;
      r_skip      <= 1'b0;
      r_jp        <= JP_NEXT;
      r_link      <= '0;
      r_list_end  <= 1'b0;
      r_overflow  <= 1'b0;
      r_cmd_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cur_addr  <= w_cur_next;
      r_ret       <= w_ret_next;
      r_ret_valid <= w_ret_valid_next;
      r_idx       <= w_idx_next;
      r_skip      <= w_skip_next;
      r_jp        <= w_jp_next;
      r_link      <= w_link_next;
      r_list_end  <= w_list_end_next;
      r_overflow  <= w_overflow_next;
      r_cmd_count <= w_cmd_count_next;
    end
  end

  assign o_cmd_wr    = w_rd_valid;
  assign o_cmd_idx   = r_idx;
  assign o_cmd_word  = w_rd_data;
  assign o_cmd_valid = (r_state == ST_DISPATCH);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_list_end  = r_list_end;
  assign o_overflow  = r_overflow;
  assign o_cmd_count = r_cmd_count;

endmodule
